ram2_ctrl: RTL and testbench

Sequencer and arbiter for the single-port RAM2 SRAM shared by instruction fetch (IF) and the data-memory stage (MEM). It grants one requester at a time and drives multi-cycle SRAM read and write strobe sequences. It returns read data with a one-cycle completion pulse and raises a pipeline stall while any request is outstanding. It sits between the IF/MEM stages and the board SRAM pins, or the simulation RAM model.

---
 rtl/ram2_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ram2_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_ctrl.sv
// ram2_ctrl: arbiter and strobe sequencer for the single-port RAM2 SRAM.
// Instruction fetch (IF) and the data-memory stage (MEM) share one SRAM.
// One requester is granted at a time from IDLE. A short read or write
// strobe sequence follows, ending in a one-cycle completion pulse back to
// the requester. MEM normally wins arbitration. After a MEM completion a
// pending fetch goes first, so data traffic cannot starve instruction fetch.
module ram2_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,

    output logic              stall_req,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic              ram_dq_oe,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5
    } state_e;

    state_e              state_q,     state_d;
    logic                src_mem_q,   src_mem_d;
    logic                last_mem_q,  last_mem_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                mem_done_q,  mem_done_d;

    logic                grant_mem;
    logic                grant_if;

    // The SRAM only decodes the low word-address bits; the rest is ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // MEM wins unless it was the last requester served and a fetch is waiting.
    assign grant_mem = mem_req & ~(last_mem_q & if_req);
    assign grant_if  = if_req & ~grant_mem;

    // State and datapath registers; reset drops any in-flight op without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            src_mem_q   <= 1'b0;
            last_mem_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_mem_q   <= src_mem_d;
            last_mem_q  <= last_mem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // Next-state logic: grant from IDLE, step through strobes, pulse on the return to IDLE.
    always_comb begin
        state_d     = state_q;
        src_mem_d   = src_mem_q;
        last_mem_d  = last_mem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    src_mem_d = 1'b1;
                    addr_d    = mem_addr[ADDR_W-1:0];
                    if (mem_we) begin
                        wdata_d = mem_wdata;
                        state_d = WR1;
                    end else begin
                        state_d = RD1;
                    end
                end else if (grant_if) begin
                    src_mem_d = 1'b0;
                    addr_d    = if_addr[ADDR_W-1:0];
                    state_d   = RD1;
                end
            end
            RD1: begin
                state_d = RD2;
            end
            RD2: begin
                state_d = IDLE;
                if (src_mem_q) begin
                    mem_rdata_d = ram_dq_i;
                    mem_done_d  = 1'b1;
                    last_mem_d  = 1'b1;
                end else begin
                    if_rdata_d  = ram_dq_i;
                    if_valid_d  = 1'b1;
                    last_mem_d  = 1'b0;
                end
            end
            WR1: begin
                state_d = WR2;
            end
            WR2: begin
                state_d = WR3;
            end
            WR3: begin
                state_d    = IDLE;
                mem_done_d = 1'b1;
                last_mem_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so reset releases them at once.
    always_comb begin
        ram_ce_n  = 1'b1;
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        ram_dq_oe = 1'b0;
        case (state_q)
            RD1, RD2: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            WR1, WR3: begin
                ram_ce_n  = 1'b0;
                ram_dq_oe = 1'b1;
            end
            WR2: begin
                ram_ce_n  = 1'b0;
                ram_we_n  = 1'b0;
                ram_dq_oe = 1'b1;
            end
            default: begin
                ram_ce_n  = 1'b1;
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_dq_o  = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_done  = mem_done_q;

    // A request still counts as outstanding until its own completion pulse.
    assign stall_req = (if_req & ~if_valid_q) | (mem_req & ~mem_done_q);

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb_ram2_ctrl: table vectors, multi-cycle corner sequences and randomized
// traffic for ram2_ctrl against a behavioural SRAM and arbitration model.
module tb_ram2_ctrl;

    localparam int DW = 32;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          stall_req;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dq_o;
    logic          ram_dq_oe;
    logic [DW-1:0] ram_dq_i;
    logic          ram_ce_n;
    logic          ram_oe_n;
    logic          ram_we_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] sram     [0:1023];
    logic [31:0] modelMem [0:1023];
    bit          lastMemModel = 1'b0;

    always #5 clk = ~clk;

    ram2_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_req(stall_req),
        .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    // Asynchronous SRAM: drives data while selected and output-enabled.
    assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[9:0]] : 32'h0;

    // SRAM write while we_n is low and the controller drives the bus.
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n && ram_dq_oe)
            sram[ram_addr[9:0]] = ram_dq_o;
    end

    // Bus protocol watch: oe/we never both low, never drive while the SRAM drives.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if ((!ram_oe_n && !ram_we_n) || (ram_dq_oe && !ram_oe_n)) begin
                bad++;
                $display("[TB] FAIL protocol: oe_n=%b we_n=%b dq_oe=%b required no overlap",
                         ram_oe_n, ram_we_n, ram_dq_oe);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] initVal(input int i);
        logic [31:0] v;
        v = 32'hA500_0000 | 32'(i);
        if (i == 4) v = 32'h1234_5678;
        return v;
    endfunction

    function automatic logic [9:0] idx(input logic [31:0] a);
        logic [31:0] m;
        m = a & 32'h0003_FFFF;
        return m[9:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " ce_n"},      32'(ram_ce_n),  32'd1);
        checkOutput({tag, " oe_n"},      32'(ram_oe_n),  32'd1);
        checkOutput({tag, " we_n"},      32'(ram_we_n),  32'd1);
        checkOutput({tag, " dq_oe"},     32'(ram_dq_oe), 32'd0);
        checkOutput({tag, " if_valid"},  32'(if_valid),  32'd0);
        checkOutput({tag, " mem_done"},  32'(mem_done),  32'd0);
        checkOutput({tag, " ram_addr"},  32'(ram_addr),  32'd0);
        checkOutput({tag, " ram_dq_o"},  ram_dq_o,       32'd0);
        checkOutput({tag, " if_rdata"},  if_rdata,       32'd0);
        checkOutput({tag, " mem_rdata"}, mem_rdata,      32'd0);
        checkOutput({tag, " stall_req"}, 32'(stall_req), 32'd0);
    endtask

    // Reference model: service order and latency derived from the arbitration rules.
    task automatic modelTxn(input bit doIf, input bit doMem, input bit memWe,
                            input logic [31:0] ifA, input logic [31:0] memA, input logic [31:0] wd,
                            output int eIf, output int eMem,
                            output logic [31:0] eIfDat, output logic [31:0] eMemDat);
        bit memFirst;
        bit serveMem;
        int t;
        eIf = -1; eMem = -1; eIfDat = 0; eMemDat = 0;
        memFirst = doMem && !(lastMemModel && doIf);
        t = 0;
        for (int k = 0; k < 2; k++) begin
            serveMem = (k == 0) ? memFirst : !memFirst;
            if (serveMem && doMem) begin
                t += memWe ? 4 : 3;
                eMem = t;
                if (memWe) modelMem[idx(memA)] = wd;
                else       eMemDat = modelMem[idx(memA)];
                lastMemModel = 1'b1;
            end else if (!serveMem && doIf) begin
                t += 3;
                eIf = t;
                eIfDat = modelMem[idx(ifA)];
                lastMemModel = 1'b0;
            end
        end
    endtask

    // Issue one or two requests together, drop each at its pulse, record what happened.
    task automatic applyStimulus(input string tag, input bit doIf, input bit doMem, input bit memWe,
                                 input logic [31:0] ifA, input logic [31:0] memA, input logic [31:0] wd,
                                 output int ifCyc, output int memCyc,
                                 output logic [31:0] ifDat, output logic [31:0] memDat,
                                 output logic [31:0] firstAddr,
                                 output int oeLow, output int weLow, output int weCyc);
        bit ifPend;
        bit memPend;
        ifCyc = -1; memCyc = -1; ifDat = 0; memDat = 0; firstAddr = 0;
        oeLow = 0; weLow = 0; weCyc = -1;
        ifPend = doIf;
        memPend = doMem;
        @(posedge clk); #1;
        if_req = doIf; if_addr = ifA;
        mem_req = doMem; mem_we = memWe; mem_addr = memA; mem_wdata = wd;
        for (int cyc = 0; cyc < 20 && (ifPend || memPend); cyc++) begin
            @(negedge clk);
            if (cyc == 1) firstAddr = 32'(ram_addr);
            if (!ram_oe_n) oeLow++;
            if (!ram_we_n) begin weLow++; weCyc = cyc; end
            checkOutput({tag, " spurious if_valid"},  32'(if_valid & ~ifPend),  32'd0);
            checkOutput({tag, " spurious mem_done"}, 32'(mem_done & ~memPend), 32'd0);
            if (if_valid && ifPend) begin
                ifCyc = cyc; ifDat = if_rdata; ifPend = 1'b0;
            end
            if (mem_done && memPend) begin
                memCyc = cyc; memDat = mem_rdata; memPend = 1'b0;
            end
            checkOutput({tag, " stall_req"}, 32'(stall_req), 32'(ifPend || memPend));
            if (!ifPend)  if_req  = 1'b0;
            if (!memPend) mem_req = 1'b0;
        end
        if (ifPend || memPend) begin
            total++; bad++;
            $display("[TB] FAIL %s timeout: pending if=%0b mem=%0b required none", tag, ifPend, memPend);
            if_req = 1'b0; mem_req = 1'b0;
        end
    endtask

    typedef struct {
        bit          doIf;
        bit          doMem;
        bit          memWe;
        logic [31:0] ifA;
        logic [31:0] memA;
        logic [31:0] wd;
        int          expIfCyc;
        int          expMemCyc;
        logic [31:0] expIfDat;
        logic [31:0] expMemDat;
        logic [31:0] expAddr;
        int          expOeLow;
        int          expWeLow;
        int          expWeCyc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int ifCyc, memCyc, oeLow, weLow, weCyc, eIf, eMem;
        logic [31:0] ifDat, memDat, firstAddr, eIfDat, eMemDat;
        int nEv, memCnt, ifCnt;
        bit evMem [8];
        int evCyc [8];
        bit sawDone;
        bit doIf, doMem, memWe;
        logic [31:0] ifA, memA, wd;

        vecs[0] = '{1, 0, 0, 32'h4,         32'h0,  32'h0,         3, -1, 32'h1234_5678, 32'h0,         32'h4,  2, 0, -1};
        vecs[1] = '{0, 1, 1, 32'h0,         32'h10, 32'hDEAD_BEEF, -1, 4, 32'h0,         32'h0,         32'h10, 0, 1,  2};
        vecs[2] = '{0, 1, 0, 32'h0,         32'h10, 32'h0,         -1, 3, 32'h0,         32'hDEAD_BEEF, 32'h10, 2, 0, -1};
        vecs[3] = '{1, 0, 0, 32'hFFFC_0003, 32'h0,  32'h0,         3, -1, 32'hA500_0003, 32'h0,         32'h3,  2, 0, -1};
        vecs[4] = '{1, 1, 0, 32'h30,        32'h20, 32'h0,         6,  3, 32'hA500_0030, 32'hA500_0020, 32'h20, 4, 0, -1};
        vecs[5] = '{1, 1, 1, 32'h10,        32'h11, 32'hCAFE_F00D, 7,  4, 32'hDEAD_BEEF, 32'h0,         32'h11, 2, 1,  2};
        vecs[6] = '{0, 1, 0, 32'h0,         32'h11, 32'h0,         -1, 3, 32'h0,         32'hCAFE_F00D, 32'h11, 2, 0, -1};
        vecs[7] = '{1, 1, 1, 32'h4,         32'h12, 32'h0BAD_CAFE, 3,  7, 32'h1234_5678, 32'h0,         32'h4,  2, 1,  5};
        vecs[8] = '{1, 1, 0, 32'h12,        32'h10, 32'h0,         3,  6, 32'h0BAD_CAFE, 32'hDEAD_BEEF, 32'h12, 4, 0, -1};

        for (int i = 0; i < 1024; i++) begin
            sram[i]     = initVal(i);
            modelMem[i] = initVal(i);
        end

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("reset");
        rst = 1'b1;

        // Table vectors: single and simultaneous requests with hand-derived results.
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].doIf, vecs[i].doMem, vecs[i].memWe,
                          vecs[i].ifA, vecs[i].memA, vecs[i].wd,
                          ifCyc, memCyc, ifDat, memDat, firstAddr, oeLow, weLow, weCyc);
            modelTxn(vecs[i].doIf, vecs[i].doMem, vecs[i].memWe, vecs[i].ifA, vecs[i].memA, vecs[i].wd,
                     eIf, eMem, eIfDat, eMemDat);
            checkOutput($sformatf("vec%0d ifCyc", i),  32'(ifCyc),  32'(vecs[i].expIfCyc));
            checkOutput($sformatf("vec%0d memCyc", i), 32'(memCyc), 32'(vecs[i].expMemCyc));
            if (vecs[i].doIf)
                checkOutput($sformatf("vec%0d if_rdata", i), ifDat, vecs[i].expIfDat);
            if (vecs[i].doMem && !vecs[i].memWe)
                checkOutput($sformatf("vec%0d mem_rdata", i), memDat, vecs[i].expMemDat);
            checkOutput($sformatf("vec%0d ram_addr", i), firstAddr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d oeLow", i), 32'(oeLow), 32'(vecs[i].expOeLow));
            checkOutput($sformatf("vec%0d weLow", i), 32'(weLow), 32'(vecs[i].expWeLow));
            checkOutput($sformatf("vec%0d weCyc", i), 32'(weCyc), 32'(vecs[i].expWeCyc));
        end

        // Fairness: clear last_mem with a fetch, then hold both requests.
        applyStimulus("prefair", 1, 0, 0, 32'h4, 32'h0, 32'h0,
                      ifCyc, memCyc, ifDat, memDat, firstAddr, oeLow, weLow, weCyc);
        modelTxn(1, 0, 0, 32'h4, 32'h0, 32'h0, eIf, eMem, eIfDat, eMemDat);
        checkOutput("prefair ifCyc", 32'(ifCyc), 32'd3);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h30;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
        nEv = 0; memCnt = 0; ifCnt = 0;
        for (int cyc = 0; cyc < 40 && !(memCnt == 3 && ifCnt == 2); cyc++) begin
            @(negedge clk);
            if (mem_done) begin
                if (nEv < 8) begin evMem[nEv] = 1'b1; evCyc[nEv] = cyc; end
                nEv++; memCnt++;
                if (memCnt == 3) mem_req = 1'b0;
            end
            if (if_valid) begin
                if (nEv < 8) begin evMem[nEv] = 1'b0; evCyc[nEv] = cyc; end
                nEv++; ifCnt++;
                if (ifCnt == 2) if_req = 1'b0;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        checkOutput("fair events", 32'(nEv), 32'd5);
        for (int k = 0; k < 5 && k < nEv; k++) begin
            checkOutput($sformatf("fair src%0d", k), 32'(evMem[k]), 32'((k % 2) == 0));
            checkOutput($sformatf("fair cyc%0d", k), 32'(evCyc[k]), 32'(3 * (k + 1)));
        end
        lastMemModel = 1'b1;

        // Reset during WR2: strobes release at once and no completion appears.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1111_2222;
        repeat (3) @(negedge clk);
        checkOutput("wr2 we_n", 32'(ram_we_n), 32'd0);
        #1 rst = 1'b0;
        #1;
        checkOutput("rstwr2 we_n",  32'(ram_we_n),  32'd1);
        checkOutput("rstwr2 ce_n",  32'(ram_ce_n),  32'd1);
        checkOutput("rstwr2 dq_oe", 32'(ram_dq_oe), 32'd0);
        mem_req = 1'b0;
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_done) sawDone = 1'b1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_done) sawDone = 1'b1;
        end
        checkOutput("rstwr2 no mem_done", 32'(sawDone), 32'd0);
        checkReset("post-reset");
        lastMemModel = 1'b0;

        // Randomized traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            doMem = 1'($urandom_range(0, 1));
            doIf  = doMem ? 1'($urandom_range(0, 1)) : 1'b1;
            memWe = 1'($urandom_range(0, 1));
            ifA   = $urandom & 32'hFFFC_003F;
            memA  = $urandom & 32'hFFFC_003F;
            wd    = $urandom;
            modelTxn(doIf, doMem, memWe, ifA, memA, wd, eIf, eMem, eIfDat, eMemDat);
            applyStimulus($sformatf("rnd%0d", r), doIf, doMem, memWe, ifA, memA, wd,
                          ifCyc, memCyc, ifDat, memDat, firstAddr, oeLow, weLow, weCyc);
            checkOutput($sformatf("rnd%0d ifCyc", r),  32'(ifCyc),  32'(eIf));
            checkOutput($sformatf("rnd%0d memCyc", r), 32'(memCyc), 32'(eMem));
            if (doIf)
                checkOutput($sformatf("rnd%0d if_rdata", r), ifDat, eIfDat);
            if (doMem && !memWe)
                checkOutput($sformatf("rnd%0d mem_rdata", r), memDat, eMemDat);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
